// File: rtl/stack_frame_ctrl_pkg.sv
// Shared stack-interface codes plus the frame controller's command and error encodings.
package stack_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        StkNone         = 3'd0,
        StkPush         = 3'd1,
        StkPop          = 3'd2,
        StkGet          = 3'd3,
        StkSet          = 3'd4,
        StkUnderflowGet = 3'd5,
        StkUnderflowSet = 3'd6,
        StkIndexReset   = 3'd7
    } stk_op_e;

    typedef enum logic [1:0] {
        StkOk        = 2'd0,
        StkOverflow  = 2'd1,
        StkUnderflow = 2'd2,
        StkBadIndex  = 2'd3
    } stk_status_e;

    typedef enum logic [1:0] {
        CmdNone   = 2'd0,
        CmdCall   = 2'd1,
        CmdReturn = 2'd2
    } cmd_e;

    typedef enum logic [2:0] {
        ErrNone           = 3'd0,
        ErrBadArgs        = 3'd1,
        ErrBadResults     = 3'd2,
        ErrFrameOverflow  = 3'd3,
        ErrFrameUnderflow = 3'd4
    } err_e;

endpackage

// File: rtl/stack_frame_mem.sv
// Frame-record LIFO: synchronous push/pop with the top entry held in a register.
module stack_frame_mem #(
    parameter int unsigned REC_W  = 48,
    parameter int unsigned FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [REC_W-1:0]  i_data,
    output logic [REC_W-1:0]  o_top,
    output logic [FRAMES:0]   o_count
);
    localparam int unsigned N = 2 ** FRAMES;

    logic [REC_W-1:0]  r_mem [N];
    logic [REC_W-1:0]  r_top;
    logic [FRAMES:0]   r_count;
    logic [FRAMES-1:0] w_below;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_count == (FRAMES+1)'(N));
    assign w_empty = (r_count == '0);
    // Slot of the entry that becomes the top after a pop.
    assign w_below = r_count[FRAMES-1:0] - FRAMES'(2);

    always_ff @(posedge clk) begin
        if (i_push && !w_full) begin
            r_mem[r_count[FRAMES-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_top   <= '0;
        end else if (i_push && !w_full) begin
            r_top   <= i_data;
            r_count <= r_count + (FRAMES+1)'(1);
        end else if (i_pop && !w_empty) begin
            r_top   <= (r_count > (FRAMES+1)'(1)) ? r_mem[w_below] : '0;
            r_count <= r_count - (FRAMES+1)'(1);
        end
    end

    assign o_top   = r_top;
    assign o_count = r_count;

endmodule

// File: rtl/stack_frame_ctrl.sv
// Call/return frame controller driving an attached operand stack.
// Define STACK_FRAME_CTRL_DEPTH_EN to expose the live frame-record count on frame_depth.
module stack_frame_ctrl
    import stack_frame_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 7,
    parameter int unsigned FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [1:0]        cmd_count,
    input  logic [WIDTH-1:0]  ret_addr_in,
    output logic              done,
    output logic [WIDTH-1:0]  ret_addr_out,
    output logic [2:0]        error,
`ifdef STACK_FRAME_CTRL_DEPTH_EN
    output logic [FRAMES:0]   frame_depth,
`endif
    output logic [2:0]        stk_op,
    output logic [WIDTH-1:0]  stk_data,
    output logic [DEPTH:0]    stk_offset,
    output logic [DEPTH:0]    stk_new_index,
    output logic [DEPTH:0]    stk_underflow_limit,
    input  logic [DEPTH:0]    stk_index,
    input  logic [WIDTH-1:0]  stk_out
);
    localparam int unsigned IW    = DEPTH + 1;
    localparam int unsigned REC_W = 2 * IW + WIDTH;

    typedef enum logic [2:0] {
        StIdle, StCall, StRetGet, StRetSet, StRetTrim, StDone, StErr
    } state_e;

    state_e             r_state;
    stk_op_e            r_op;
    err_e               r_error;
    logic [IW-1:0]      r_limit;
    logic [IW-1:0]      r_src;
    logic [IW-1:0]      r_offset;
    logic [IW-1:0]      r_new_index;
    logic [WIDTH-1:0]   r_ret_in;
    logic [WIDTH-1:0]   r_ret_addr;
    logic [1:0]         r_cnt;
    logic [1:0]         r_i;
    logic               r_done;

    logic [IW-1:0]      w_count_ext;
    logic [IW-1:0]      w_avail;
    logic [IW-1:0]      w_src;
    logic [REC_W-1:0]   w_top;
    logic [IW-1:0]      w_top_limit;
    logic [IW-1:0]      w_top_base;
    logic [WIDTH-1:0]   w_top_ret;
    logic [FRAMES:0]    w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;

    assign w_count_ext = IW'(cmd_count);
    assign w_avail     = stk_index - r_limit;
    // First argument on CALL, first result on RETURN.
    assign w_src       = stk_index - w_count_ext;
    assign {w_top_limit, w_top_ret, w_top_base} = w_top;
    assign w_full      = (w_count == (FRAMES+1)'(2 ** FRAMES));
    assign w_empty     = (w_count == '0);
    assign w_accept    = cmd_valid && cmd_ready && (cmd == CmdCall || cmd == CmdReturn);

    stack_frame_mem #(
        .REC_W  (REC_W),
        .FRAMES (FRAMES)
    ) u_frames (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_state == StCall),
        .i_pop   (r_state == StDone),
        .i_data  ({r_limit, r_ret_in, r_src}),
        .o_top   (w_top),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_op        <= StkNone;
            r_error     <= ErrNone;
            r_limit     <= '0;
            r_src       <= '0;
            r_offset    <= '0;
            r_new_index <= '0;
            r_ret_in    <= '0;
            r_ret_addr  <= '0;
            r_cnt       <= '0;
            r_i         <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_op   <= StkNone;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cnt    <= cmd_count;
                        r_i      <= '0;
                        r_src    <= w_src;
                        r_ret_in <= ret_addr_in;
                        if (cmd == CmdCall) begin
                            if (w_avail < w_count_ext) begin
                                r_error <= ErrBadArgs;
                                r_state <= StErr;
                            end else if (w_full) begin
                                r_error <= ErrFrameOverflow;
                                r_state <= StErr;
                            end else begin
                                r_state <= StCall;
                            end
                        end else if (w_empty) begin
                            r_error <= ErrFrameUnderflow;
                            r_state <= StErr;
                        end else if (w_avail < w_count_ext) begin
                            r_error <= ErrBadResults;
                            r_state <= StErr;
                        end else if (cmd_count == 2'd0) begin
                            r_op        <= StkIndexReset;
                            r_new_index <= w_top_base;
                            r_state     <= StRetTrim;
                        end else begin
                            r_op     <= StkUnderflowGet;
                            r_offset <= w_src;
                            r_state  <= StRetGet;
                        end
                    end
                end
                StCall: begin
                    r_limit <= r_src;
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                StRetGet: begin
                    r_op     <= StkUnderflowSet;
                    r_offset <= w_top_base + IW'(r_i);
                    r_state  <= StRetSet;
                end
                StRetSet: begin
                    if (r_i == r_cnt - 2'd1) begin
                        r_op        <= StkIndexReset;
                        r_new_index <= w_top_base + IW'(r_cnt);
                        r_state     <= StRetTrim;
                    end else begin
                        r_i      <= r_i + 2'd1;
                        r_op     <= StkUnderflowGet;
                        r_offset <= r_src + IW'(r_i + 2'd1);
                        r_state  <= StRetGet;
                    end
                end
                StRetTrim: r_state <= StDone;
                StDone: begin
                    r_limit    <= w_top_limit;
                    r_ret_addr <= w_top_ret;
                    r_done     <= 1'b1;
                    r_state    <= StIdle;
                end
                StErr: begin
                    r_error <= ErrNone;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cmd_ready           = (r_state == StIdle);
    assign done                = r_done;
    assign ret_addr_out        = r_ret_addr;
    assign error               = r_error;
    assign stk_op              = r_op;
    // The stack presents the fetched word in the cycle after UNDERFLOW_GET.
    assign stk_data            = (r_state == StRetSet) ? stk_out : '0;
    assign stk_offset          = r_offset;
    assign stk_new_index       = r_new_index;
    assign stk_underflow_limit = r_limit;

`ifdef STACK_FRAME_CTRL_DEPTH_EN
    assign frame_depth = w_count;
`endif

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Scoreboard bench for stack_frame_ctrl with a small behavioural operand stack.
module tb_stack_frame_ctrl;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 7;
    localparam int FRAMES = 4;

    typedef struct {
        string name;
        int    kind;   // 1 stack op, 2 done, 3 error
        int    a;
        int    b;
        int    c;
        int    cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd;
    logic [1:0]       cmd_count;
    logic [WIDTH-1:0] ret_addr_in;
    logic             done;
    logic [WIDTH-1:0] ret_addr_out;
    logic [2:0]       error;
    logic [2:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [DEPTH:0]   stk_offset;
    logic [DEPTH:0]   stk_new_index;
    logic [DEPTH:0]   stk_underflow_limit;
    logic [DEPTH:0]   stk_index = '0;
    logic [WIDTH-1:0] stk_out = '0;

    logic [WIDTH-1:0] smem [256];
    logic             push_req;
    logic [WIDTH-1:0] push_val;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    stack_frame_ctrl #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .FRAMES (FRAMES)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_count           (cmd_count),
        .ret_addr_in         (ret_addr_in),
        .done                (done),
        .ret_addr_out        (ret_addr_out),
        .error               (error),
        .stk_op              (stk_op),
        .stk_data            (stk_data),
        .stk_offset          (stk_offset),
        .stk_new_index       (stk_new_index),
        .stk_underflow_limit (stk_underflow_limit),
        .stk_index           (stk_index),
        .stk_out             (stk_out)
    );

    // Operand stack model: synchronous read, write and index reset.
    always @(posedge clk) begin
        if (reset) begin
            stk_index <= '0;
        end else begin
            if (push_req) begin
                smem[stk_index] <= push_val;
                stk_index       <= stk_index + 1'b1;
            end
            case (stk_op)
                3'd5:    stk_out <= smem[stk_offset];
                3'd6:    smem[stk_offset] <= stk_data;
                3'd7:    stk_index <= stk_new_index;
                default: ;
            endcase
        end
    end

    task automatic obs(input int kind, input int a, input int b, input int c);
        ev_t e;
        int  rel;
        rel = cyc - acc_cyc;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h c=%0h cyc=%0d, required none",
                     kind, a, b, c, rel);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c || e.cyc != rel) begin
                errors++;
                $display("FAIL %s: got kind=%0d a=%0h b=%0h c=%0h cyc=%0d, required kind=%0d a=%0h b=%0h c=%0h cyc=%0d",
                         e.name, kind, a, b, c, rel, e.kind, e.a, e.b, e.c, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (stk_op != 3'd0)
                obs(1, int'(stk_op), (stk_op == 3'd7) ? int'(stk_new_index) : int'(stk_offset),
                    int'(stk_data));
            if (done)
                obs(2, int'(ret_addr_out), int'(stk_underflow_limit), 0);
            if (error != 3'd0)
                obs(3, int'(error), int'(stk_underflow_limit), 0);
            if (cmd_valid && cmd_ready && cmd != 2'd0)
                acc_cyc = cyc;
        end
    end

    task automatic exp_ev(input string name, input int kind, input int a, input int b,
                          input int c, input int cy);
        ev_t e;
        e = '{name: name, kind: kind, a: a, b: b, c: c, cyc: cy};
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] v);
        push_req = 1'b1;
        push_val = v;
        @(posedge clk);
        #1;
        push_req = 1'b0;
    endtask

    task automatic send(input logic [1:0] c, input logic [1:0] n, input logic [WIDTH-1:0] ra);
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        cmd         = c;
        cmd_count   = n;
        ret_addr_in = ra;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 2'd0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending events, required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_count = '0; ret_addr_in = '0;
        push_req = 1'b0; push_val = '0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_ret_addr", int'(ret_addr_out), 0);
        chk("reset_stk_op", int'(stk_op), 0);
        chk("reset_limit", int'(stk_underflow_limit), 0);

        // CALL with two args at index 5
        for (int k = 0; k < 5; k++) push_word(32'h100 + k);
        exp_ev("call_done", 2, 'h0, 3, 0, 2);
        send(2'd1, 2'd2, 32'h40);
        drain("call");
        chk("call_limit", int'(stk_underflow_limit), 3);

        // RETURN two results with the stack grown to 7
        push_word(32'h200);
        push_word(32'h201);
        exp_ev("ret_get0", 1, 5, 5, 0, 1);
        exp_ev("ret_set0", 1, 6, 3, 'h200, 2);
        exp_ev("ret_get1", 1, 5, 6, 0, 3);
        exp_ev("ret_set1", 1, 6, 4, 'h201, 4);
        exp_ev("ret_trim", 1, 7, 5, 0, 5);
        exp_ev("ret_done", 2, 'h40, 0, 0, 7);
        send(2'd2, 2'd2, 32'h0);
        drain("ret2");
        chk("ret_slot3", int'(smem[3]), 'h200);
        chk("ret_slot4", int'(smem[4]), 'h201);

        // RETURN with no frame records
        exp_ev("underflow_err", 3, 4, 0, 0, 1);
        send(2'd2, 2'd0, 32'h0);
        drain("underflow");

        // BAD_ARGS, then a RETURN whose results already sit at the base
        exp_ev("call0_done", 2, 'h40, 5, 0, 2);
        send(2'd1, 2'd0, 32'h11);
        drain("call0");
        push_word(32'h300);
        push_word(32'h301);
        exp_ev("badargs_err", 3, 1, 5, 0, 1);
        send(2'd1, 2'd3, 32'h99);
        drain("badargs");
        chk("badargs_limit", int'(stk_underflow_limit), 5);
        exp_ev("inplace_get0", 1, 5, 5, 0, 1);
        exp_ev("inplace_set0", 1, 6, 5, 'h300, 2);
        exp_ev("inplace_get1", 1, 5, 6, 0, 3);
        exp_ev("inplace_set1", 1, 6, 6, 'h301, 4);
        exp_ev("inplace_trim", 1, 7, 7, 0, 5);
        exp_ev("inplace_done", 2, 'h11, 0, 0, 7);
        send(2'd2, 2'd2, 32'h0);
        drain("inplace");

        // Fill the frame records, then overflow
        for (int k = 0; k < 16; k++) begin
            exp_ev("nest_done", 2, 'h11, 7, 0, 2);
            send(2'd1, 2'd0, 32'h1000 + k);
            drain("nest");
        end
        exp_ev("overflow_err", 3, 3, 7, 0, 1);
        send(2'd1, 2'd0, 32'h2000);
        drain("overflow");
        chk("overflow_limit", int'(stk_underflow_limit), 7);

        exp_ev("pop1_trim", 1, 7, 7, 0, 1);
        exp_ev("pop1_done", 2, 'h100f, 7, 0, 3);
        send(2'd2, 2'd0, 32'h0);
        drain("pop1");
        exp_ev("pop2_trim", 1, 7, 7, 0, 1);
        exp_ev("pop2_done", 2, 'h100e, 7, 0, 3);
        send(2'd2, 2'd0, 32'h0);
        drain("pop2");
        exp_ev("badres_err", 3, 2, 7, 0, 1);
        send(2'd2, 2'd1, 32'h0);
        drain("badres");

        // Reset while in RET_SET
        push_word(32'h500);
        exp_ev("rst_get", 1, 5, 7, 0, 1);
        exp_ev("rst_set", 1, 6, 7, 'h500, 2);
        send(2'd2, 2'd1, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_stk_op", int'(stk_op), 0);
        chk("rst_limit", int'(stk_underflow_limit), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        drain("rst");

        exp_ev("post_rst_underflow", 3, 4, 0, 0, 1);
        send(2'd2, 2'd0, 32'h0);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
